ysyx_2022040010_mem_resp: RTL and testbench

YSYX_2022040010_MEM_RESP -- requirements
Module: ysyx_2022040010_mem_resp

---
 rtl/ysyx_2022040010_mem_resp.sv | 150 +++++++++++++++
 tb/tb_ysyx_2022040010_mem_resp.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_mem_resp.sv
// Fixed-latency 64-bit word memory responder with level-held read/write requests.
// Define YSYX_MEM_RESP_ADDR_CHK_EN to flag out-of-range addresses instead of wrapping them.
module ysyx_2022040010_mem_resp #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          DEPTH     = 256,
  parameter int          LAT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ar_e_i,
  input  logic [3:0]  ar_id_i,
  input  logic [31:0] ar_addr_i,
  output logic [63:0] r_data_o,
  output logic [3:0]  r_id_o,
  output logic        r_refresh_o,
  output logic        r_err_o,
  input  logic        aw_e_i,
  input  logic [31:0] aw_addr_i,
  input  logic [63:0] w_data_i,
  input  logic [7:0]  w_mask_i,
  output logic        b_refresh_o,
  output logic        busy_o
);

  localparam int          IW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);
  localparam logic [63:0] ERR_WORD = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [3:0]  id_q;
  logic [63:0] wdata_q;
  logic [7:0]  mask_q;

  logic [63:0] mem [DEPTH];

  logic [31:0] rd_addr;
  logic [63:0] rd_word;
  logic        rd_err;
  logic        wr_ok;
  logic        wr_commit;

  function automatic logic [IW-1:0] word_idx(input logic [31:0] addr);
    return IW'((addr - ADDR_BASE) >> 3);
  endfunction

`ifdef YSYX_MEM_RESP_ADDR_CHK_EN
  function automatic logic in_range(input logic [31:0] addr);
    return (addr - ADDR_BASE) < 32'(8 * DEPTH);
  endfunction

  assign rd_err = !in_range(rd_addr);
  assign wr_ok  = in_range(addr_q);
`else
  assign rd_err = 1'b0;
  assign wr_ok  = 1'b1;
`endif

  // With LAT=1 the response leaves on the sampling edge, so read straight from the request port.
  assign rd_addr   = (state == IDLE) ? ar_addr_i : addr_q;
  assign rd_word   = rd_err ? ERR_WORD : mem[word_idx(rd_addr)];
  assign wr_commit = (state == WR_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      addr_q      <= 32'd0;
      id_q        <= 4'd0;
      wdata_q     <= 64'd0;
      mask_q      <= 8'd0;
      r_data_o    <= 64'd0;
      r_id_o      <= 4'd0;
      r_refresh_o <= 1'b0;
      r_err_o     <= 1'b0;
      b_refresh_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      r_data_o    <= 64'd0;
      r_id_o      <= 4'd0;
      r_refresh_o <= 1'b0;
      r_err_o     <= 1'b0;
      b_refresh_o <= 1'b0;
      case (state)
        IDLE: begin
          if (aw_e_i) begin
            state       <= WR_WAIT;
            cnt         <= CNT_INIT;
            addr_q      <= aw_addr_i;
            wdata_q     <= w_data_i;
            mask_q      <= w_mask_i;
            busy_o      <= 1'b1;
            b_refresh_o <= (LAT == 1);
          end else if (ar_e_i) begin
            state  <= RD_WAIT;
            cnt    <= CNT_INIT;
            addr_q <= ar_addr_i;
            id_q   <= ar_id_i;
            busy_o <= 1'b1;
            if (LAT == 1) begin
              r_refresh_o <= 1'b1;
              r_data_o    <= rd_word;
              r_id_o      <= ar_id_i;
              r_err_o     <= rd_err;
            end
          end
        end
        RD_WAIT, WR_WAIT: begin
          // The response is visible during the cycle in which the counter reads zero.
          if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              if (state == RD_WAIT) begin
                r_refresh_o <= 1'b1;
                r_data_o    <= rd_word;
                r_id_o      <= id_q;
                r_err_o     <= rd_err;
              end else begin
                b_refresh_o <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Memory is never reset; an async reset drops state to IDLE before the edge, cancelling the commit.
  always_ff @(posedge clk) begin
    if (wr_commit && wr_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (mask_q[b]) mem[word_idx(addr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_mem_resp.sv
// Bench for ysyx_2022040010_mem_resp: directed vector table, corner sequences, randomized traffic
// against an array-based memory model.
module tb_ysyx_2022040010_mem_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;
  localparam logic [63:0] ERRW  = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ar_e_i = 1'b0;
  logic [3:0]  ar_id_i = 4'd0;
  logic [31:0] ar_addr_i = 32'd0;
  logic [63:0] r_data_o;
  logic [3:0]  r_id_o;
  logic        r_refresh_o;
  logic        r_err_o;
  logic        aw_e_i = 1'b0;
  logic [31:0] aw_addr_i = 32'd0;
  logic [63:0] w_data_i = 64'd0;
  logic [7:0]  w_mask_i = 8'd0;
  logic        b_refresh_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  logic [63:0] mdl [DEPTH];

  ysyx_2022040010_mem_resp #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ar_e_i(ar_e_i), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .r_data_o(r_data_o), .r_id_o(r_id_o), .r_refresh_o(r_refresh_o), .r_err_o(r_err_o),
    .aw_e_i(aw_e_i), .aw_addr_i(aw_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
    .b_refresh_o(b_refresh_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output rules that hold in every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("pulse_exclusive", 64'(r_refresh_o & b_refresh_o), 64'd0);
      if (!r_refresh_o) chk("rdata_idle_zero", {r_data_o[63:4], r_data_o[3:0] | r_id_o | {3'd0, r_err_o}}, 64'd0);
    end
  end

  function automatic int midx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'((off / 32'd8) % 32'(DEPTH));
  endfunction

  function automatic bit mdl_ok(input logic [31:0] addr);
`ifdef YSYX_MEM_RESP_ADDR_CHK_EN
    return (addr - BASE) < 32'(8 * DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  task automatic mdl_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] mask);
    if (mdl_ok(addr)) begin
      for (int b = 0; b < 8; b++) if (mask[b]) mdl[midx(addr)][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  function automatic logic [63:0] mdl_read(input logic [31:0] addr);
    return mdl_ok(addr) ? mdl[midx(addr)] : ERRW;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, measure latency, then release and confirm a clean return to IDLE.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [63:0] data,
                        input logic [7:0] mask, input logic [3:0] id, input bit hold,
                        output logic [63:0] got, output logic got_err);
    int n;
    bit seen;
    if (wr) begin
      aw_e_i = 1'b1; aw_addr_i = addr; w_data_i = data; w_mask_i = mask;
    end else begin
      ar_e_i = 1'b1; ar_addr_i = addr; ar_id_i = id;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = wr ? b_refresh_o : r_refresh_o;
    end
    chk(wr ? "wr_latency" : "rd_latency", 64'(n), 64'(LAT));
    got = r_data_o;
    got_err = r_err_o;
    if (!wr) chk("rd_id", 64'(r_id_o), 64'(id));
    if (hold) tick();
    aw_e_i = 1'b0;
    ar_e_i = 1'b0;
    repeat (3) begin
      tick();
      chk("no_extra_pulse", 64'(r_refresh_o | b_refresh_o), 64'd0);
    end
    chk("idle_after_txn", 64'(busy_o), 64'd0);
    if (wr) mdl_write(addr, data, mask);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [3:0]  id;
    logic [63:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [63:0] got, exp;
    logic        gerr, eerr;
    bit          wr, hold;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  m;
    logic [3:0]  id;
    int          r, n, nb, nr;

    vt[0]  = '{1'b1, 32'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, 4'h0, 64'h0, 1'b0};
    vt[1]  = '{1'b0, 32'h8000_0000, 64'h0, 8'h00, 4'h1, 64'h1122_3344_5566_7788, 1'b0};
    vt[2]  = '{1'b1, 32'h8000_0008, 64'h0, 8'hFF, 4'h0, 64'h0, 1'b0};
    vt[3]  = '{1'b1, 32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 4'h0, 64'h0, 1'b0};
    vt[4]  = '{1'b0, 32'h8000_0008, 64'h0, 8'h00, 4'h2, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vt[5]  = '{1'b1, 32'h8000_0008, 64'h1234_5678_9ABC_DEF0, 8'h00, 4'h0, 64'h0, 1'b0};
    vt[6]  = '{1'b0, 32'h8000_000C, 64'h0, 8'h00, 4'h3, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vt[7]  = '{1'b1, 32'h8000_07F8, 64'hCAFE_F00D_0BAD_F00D, 8'hFF, 4'h0, 64'h0, 1'b0};
`ifdef YSYX_MEM_RESP_ADDR_CHK_EN
    vt[8]  = '{1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, 4'h4, ERRW, 1'b1};
    vt[11] = '{1'b0, 32'h8000_07F8, 64'h0, 8'h00, 4'h6, 64'hCAFE_F00D_0BAD_F00D, 1'b0};
`else
    vt[8]  = '{1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, 4'h4, 64'hCAFE_F00D_0BAD_F00D, 1'b0};
    vt[11] = '{1'b0, 32'h8000_07F8, 64'h0, 8'h00, 4'h6, 64'h0, 1'b0};
`endif
    vt[9]  = '{1'b0, 32'h8000_07FF, 64'h0, 8'h00, 4'h5, 64'hCAFE_F00D_0BAD_F00D, 1'b0};
    vt[10] = '{1'b1, 32'h7FFF_FFF8, 64'h0, 8'hFF, 4'h0, 64'h0, 1'b0};

    repeat (3) tick();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_r_refresh", 64'(r_refresh_o), 64'd0);
    chk("rst_b_refresh", 64'(b_refresh_o), 64'd0);
    chk("rst_r_data", r_data_o, 64'd0);
    chk("rst_r_id", 64'(r_id_o), 64'd0);
    chk("rst_r_err", 64'(r_err_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_txn(vt[i].wr, vt[i].addr, vt[i].data, vt[i].mask, vt[i].id, 1'b0, got, gerr);
      if (!vt[i].wr) begin
        chk($sformatf("vec%0d_data", i), got, vt[i].exp);
        chk($sformatf("vec%0d_err", i), 64'(gerr), 64'(vt[i].exp_err));
      end
    end

    // Request held one cycle past its pulse must not be served twice.
    do_txn(1'b0, 32'h8000_0000, 64'h0, 8'h00, 4'h9, 1'b1, got, gerr);
    chk("held_data", got, 64'h1122_3344_5566_7788);

    // Simultaneous write and read to one word: write first, read sees the new value.
    aw_e_i = 1'b1; aw_addr_i = 32'h8000_0010; w_data_i = 64'hA5; w_mask_i = 8'hFF;
    ar_e_i = 1'b1; ar_addr_i = 32'h8000_0010; ar_id_i = 4'h3;
    n = 0; nb = -1; nr = -1; got = 64'd0;
    while (nr < 0 && n < 60) begin
      tick();
      n++;
      if (b_refresh_o) begin nb = n; aw_e_i = 1'b0; end
      if (r_refresh_o) begin nr = n; got = r_data_o; ar_e_i = 1'b0; end
    end
    aw_e_i = 1'b0; ar_e_i = 1'b0;
    chk("simul_b_cycle", 64'(nb), 64'(LAT));
    chk("simul_r_cycle", 64'(nr), 64'(2 * LAT + 2));
    chk("simul_r_data", got, 64'hA5);
    mdl_write(32'h8000_0010, 64'hA5, 8'hFF);
    repeat (3) tick();

    for (int i = 0; i < 16; i++) begin
      do_txn(1'b1, BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 4'h0, 1'b0, got, gerr);
    end

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = BASE + 32'(8 * DEPTH) + 32'(8 * r) + 32'($urandom_range(0, 7));
      else a = BASE + 32'(8 * r) + 32'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      m = 8'($urandom);
      id = 4'($urandom);
      exp = mdl_read(a);
      eerr = !mdl_ok(a);
      do_txn(wr, a, d, m, id, hold, got, gerr);
      if (!wr) begin
        chk($sformatf("rand%0d_data", i), got, exp);
        chk($sformatf("rand%0d_err", i), 64'(gerr), 64'(eerr));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset during WR_WAIT: no pulse, no memory change.
    aw_e_i = 1'b1; aw_addr_i = BASE + 32'd40; w_data_i = ~mdl[5]; w_mask_i = 8'hFF;
    tick();
    rst = 1'b1; aw_e_i = 1'b0;
    #1;
    chk("wr_abort_busy", 64'(busy_o), 64'd0);
    chk("wr_abort_b", 64'(b_refresh_o), 64'd0);
    tick();
    chk("wr_abort_b_late", 64'(b_refresh_o), 64'd0);
    rst = 1'b0;
    do_txn(1'b0, BASE + 32'd40, 64'h0, 8'h00, 4'hA, 1'b0, got, gerr);
    chk("wr_abort_mem", got, mdl[5]);

    // Reset during RD_WAIT: no pulse; reissued read has normal latency.
    ar_e_i = 1'b1; ar_addr_i = BASE; ar_id_i = 4'h7;
    tick();
    rst = 1'b1; ar_e_i = 1'b0;
    #1;
    chk("rd_abort_busy", 64'(busy_o), 64'd0);
    chk("rd_abort_r", 64'(r_refresh_o), 64'd0);
    tick();
    chk("rd_abort_r_late", 64'(r_refresh_o), 64'd0);
    rst = 1'b0;
    do_txn(1'b0, BASE, 64'h0, 8'h00, 4'h7, 1'b0, got, gerr);
    chk("rd_reissue_data", got, mdl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
